// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and the instruction-class decoder for the multi-cycle MIPS controller.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [5:0] {
        OpSpecial = 6'h00,
        OpRegimm  = 6'h01,
        OpJ       = 6'h02,
        OpJal     = 6'h03,
        OpBeq     = 6'h04,
        OpBne     = 6'h05,
        OpBlez    = 6'h06,
        OpBgtz    = 6'h07,
        OpAddiu   = 6'h09,
        OpLb      = 6'h20,
        OpLh      = 6'h21,
        OpLwl     = 6'h22,
        OpLw      = 6'h23,
        OpLbu     = 6'h24,
        OpLhu     = 6'h25,
        OpLwr     = 6'h26,
        OpSb      = 6'h28,
        OpSh      = 6'h29,
        OpSwl     = 6'h2a,
        OpSw      = 6'h2b,
        OpSwr     = 6'h2e
    } opcode_t;

    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnJalr  = 6'h09;
    localparam logic [5:0] FnMthi  = 6'h11;
    localparam logic [5:0] FnMtlo  = 6'h13;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1a;
    localparam logic [5:0] FnDivu  = 6'h1b;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMem,
        StMuldiv,
        StHalt
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PcSelNext   = 2'b00,
        PcSelBranch = 2'b01,
        PcSelJump   = 2'b10,
        PcSelReg    = 2'b11
    } pc_sel_t;

    typedef struct packed {
        logic    load;
        logic    store;
        logic    muldiv;
        logic    cond_branch;  // taken only when is_true
        logic    jump;         // always taken
        logic    link;         // writes the return address when taken
        logic    rd_write;     // plain ALU result write
        logic    hilo;         // MTHI/MTLO
        pc_sel_t target;
    } decode_t;

    // Classify the instruction; anything unrecognised behaves as an I-type ALU op.
    function automatic decode_t decode(logic [31:0] ir);
        decode_t d;
        d = '0;
        case (opcode_t'(ir[31:26]))
            OpSpecial: begin
                case (ir[5:0])
                    FnJr: begin
                        d.jump   = 1'b1;
                        d.target = PcSelReg;
                    end
                    FnJalr: begin
                        d.jump   = 1'b1;
                        d.link   = 1'b1;
                        d.target = PcSelReg;
                    end
                    FnMthi, FnMtlo:                   d.hilo   = 1'b1;
                    FnMult, FnMultu, FnDiv, FnDivu:   d.muldiv = 1'b1;
                    default:                          d.rd_write = 1'b1;
                endcase
            end
            OpRegimm: begin
                d.cond_branch = 1'b1;
                d.link        = ir[20];  // BLTZAL/BGEZAL
                d.target      = PcSelBranch;
            end
            OpJ: begin
                d.jump   = 1'b1;
                d.target = PcSelJump;
            end
            OpJal: begin
                d.jump   = 1'b1;
                d.link   = 1'b1;
                d.target = PcSelJump;
            end
            OpBeq, OpBne, OpBlez, OpBgtz: begin
                d.cond_branch = 1'b1;
                d.target      = PcSelBranch;
            end
            OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu, OpLwr: d.load  = 1'b1;
            OpSb, OpSh, OpSwl, OpSw, OpSwr:              d.store = 1'b1;
            default:                                     d.rd_write = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/bus bundle between the controller and the Avalon masters plus datapath.
interface mips_multicycle_ctrl_if;

    logic        clk_enable;
    logic [31:0] instr_readdata;
    logic        waitrequest;
    logic        is_true;
    logic [1:0]  addr_low;
    logic        pc_is_zero;

    logic        active;
    logic        instr_read;
    logic        data_read;
    logic        data_write;
    logic [3:0]  byte_enable;
    logic        reg_write_enable;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        muldiv_start;
    logic        hilo_write;

    modport master (
        input  clk_enable, instr_readdata, waitrequest, is_true, addr_low, pc_is_zero,
        output active, instr_read, data_read, data_write, byte_enable, reg_write_enable,
               pc_en, pc_sel, muldiv_start, hilo_write
    );

    modport slave (
        output clk_enable, instr_readdata, waitrequest, is_true, addr_low, pc_is_zero,
        input  active, instr_read, data_read, data_write, byte_enable, reg_write_enable,
               pc_en, pc_sel, muldiv_start, hilo_write
    );

endinterface

// File: rtl/mips_multicycle_ctrl_byte_enable_gen.sv
// Data lane enables and misalignment flag from the load/store opcode and address low bits.
module mips_byte_enable_gen
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [1:0] addr_low_i,
    output logic [3:0] byte_enable_o,
    output logic       misalign_o
);

    // Lane select per access size; LWL/LWR/SWL/SWR never fault.
    always_comb begin
        byte_enable_o = 4'b0000;
        misalign_o    = 1'b0;
        case (opcode_t'(opcode_i))
            OpLw, OpSw: begin
                byte_enable_o = 4'b1111;
                misalign_o    = (addr_low_i != 2'b00);
            end
            OpLwl, OpLwr, OpSwl, OpSwr: byte_enable_o = 4'b1111;
            OpLh, OpLhu, OpSh: begin
                byte_enable_o = addr_low_i[1] ? 4'b1100 : 4'b0011;
                misalign_o    = addr_low_i[0];
            end
            OpLb, OpLbu, OpSb: byte_enable_o = 4'b0001 << addr_low_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/exec/mem/muldiv sequencing with Avalon stalls,
// branch delay slot tracking and halt on jump-to-zero.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter bit          DELAY_SLOT    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam int unsigned CntW = $clog2(MULDIV_CYCLES + 1);

    ctrl_state_t     state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pend_q, pend_d;
    pc_sel_t         pend_sel_q, pend_sel_d;
    logic            pend_halt_q, pend_halt_d;

    decode_t         dec;
    logic [3:0]      be;
    logic            misalign;
    logic            retire;
    logic            taken;

    logic            instr_read, data_read, data_write;
    logic [3:0]      byte_enable;
    logic            reg_write_enable, pc_en, muldiv_start, hilo_write;
    pc_sel_t         pc_sel;

    assign dec = decode(ir_q);

    mips_byte_enable_gen u_be_gen (
        .opcode_i      (ir_q[31:26]),
        .addr_low_i    (bus.addr_low),
        .byte_enable_o (be),
        .misalign_o    (misalign)
    );

    // State, IR, muldiv counter and pending-redirect registers; frozen while clk_enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFetch;
            ir_q        <= '0;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pend_sel_q  <= PcSelNext;
            pend_halt_q <= 1'b0;
        end else if (bus.clk_enable) begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            pend_sel_q  <= pend_sel_d;
            pend_halt_q <= pend_halt_d;
        end
    end

    // Next state and strobes; every instruction funnels through one retire point.
    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        count_d          = count_q;
        pend_d           = pend_q;
        pend_sel_d       = pend_sel_q;
        pend_halt_d      = pend_halt_q;
        instr_read       = 1'b0;
        data_read        = 1'b0;
        data_write       = 1'b0;
        byte_enable      = 4'b0000;
        reg_write_enable = 1'b0;
        pc_en            = 1'b0;
        pc_sel           = PcSelNext;
        muldiv_start     = 1'b0;
        hilo_write       = 1'b0;
        retire           = 1'b0;
        taken            = (state_q == StExec) &&
                           (dec.jump || (dec.cond_branch && bus.is_true));

        unique case (state_q)
            StFetch: begin
                instr_read = 1'b1;
                if (!bus.waitrequest) begin
                    ir_d    = bus.instr_readdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (dec.load || dec.store) begin
                    state_d = StMem;
                end else if (dec.muldiv) begin
                    muldiv_start = 1'b1;
                    count_d      = CntW'(MULDIV_CYCLES - 1);
                    state_d      = StMuldiv;
                end else begin
                    retire           = 1'b1;
                    reg_write_enable = dec.rd_write | (dec.link & taken);
                    hilo_write       = dec.hilo;
                end
            end
            StMem: begin
                // A misaligned access never reaches the bus and retires as a no-op.
                if (misalign) begin
                    retire = 1'b1;
                end else begin
                    data_read   = dec.load;
                    data_write  = dec.store;
                    byte_enable = be;
                    if (!bus.waitrequest) begin
                        retire           = 1'b1;
                        reg_write_enable = dec.load;
                    end
                end
            end
            StMuldiv: begin
                if (count_q == '0) begin
                    retire     = 1'b1;
                    hilo_write = 1'b1;
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase

        if (retire) begin
            pc_en   = 1'b1;
            state_d = StFetch;
            // This instruction is the delay slot of an earlier taken branch.
            if (pend_q) begin
                pc_sel = pend_sel_q;
                pend_d = 1'b0;
                if (pend_halt_q) begin
                    state_d = StHalt;
                end
            end
            if (taken) begin
                if (DELAY_SLOT) begin
                    pend_d      = 1'b1;
                    pend_sel_d  = dec.target;
                    pend_halt_d = bus.pc_is_zero;
                end else begin
                    pc_sel = dec.target;
                    if (bus.pc_is_zero) begin
                        state_d = StHalt;
                    end
                end
            end
        end

        // Strobes drop the moment reset asserts, abandoning any in-flight transfer.
        if (!reset) begin
            instr_read       = 1'b0;
            data_read        = 1'b0;
            data_write       = 1'b0;
            byte_enable      = 4'b0000;
            reg_write_enable = 1'b0;
            pc_en            = 1'b0;
            pc_sel           = PcSelNext;
            muldiv_start     = 1'b0;
            hilo_write       = 1'b0;
        end
    end

    assign bus.active           = (state_q != StHalt);
    assign bus.instr_read       = instr_read;
    assign bus.data_read        = data_read;
    assign bus.data_write       = data_write;
    assign bus.byte_enable      = byte_enable;
    assign bus.reg_write_enable = reg_write_enable;
    assign bus.pc_en            = pc_en;
    assign bus.pc_sel           = pc_sel;
    assign bus.muldiv_start     = muldiv_start;
    assign bus.hilo_write       = hilo_write;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-level model expands each directed
// instruction into its expected cycle-by-cycle strobes; a compare process checks every cycle.
module tb_mips_multicycle_ctrl;

    localparam int unsigned MD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(
        .MULDIV_CYCLES (MD),
        .DELAY_SLOT    (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum {KAlu, KLoad, KStore, KBranch, KJump, KMulDiv} kind_e;

    typedef struct {
        string       tag;
        string       pin;
        logic [31:0] rdata;
        logic        wr;
        logic        is_true;
        logic [1:0]  al;
        logic        pz;
        logic        act, ird, drd, dwr;
        logic [3:0]  be;
        logic        rwe, pcen;
        logic [1:0]  sel;
        logic        ms, hw;
    } cyc_t;

    cyc_t       sched[$];
    cyc_t       cur;
    bit         cur_valid;
    int         n_cmp, n_bad;

    // Architectural model state: pending redirect after a taken branch.
    bit         m_pend, m_phalt, m_halted;
    logic [1:0] m_psel;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic cyc_t blank(input string tag);
        cyc_t c;
        c.tag = tag;   c.pin = "";
        c.rdata = '0;  c.wr = 1'b0;  c.is_true = 1'b0; c.al = 2'b00; c.pz = 1'b0;
        c.act = 1'b1;  c.ird = 1'b0; c.drd = 1'b0;     c.dwr = 1'b0; c.be = 4'b0000;
        c.rwe = 1'b0;  c.pcen = 1'b0; c.sel = 2'b00;   c.ms = 1'b0;  c.hw = 1'b0;
        return c;
    endfunction

    function automatic logic [13:0] pack(input cyc_t c);
        return {c.act, c.ird, c.drd, c.dwr, c.be, c.rwe, c.pcen, c.sel, c.ms, c.hw};
    endfunction

    // Retirement: PC advances; a pending redirect applies now; a taken branch becomes pending.
    task automatic push_retire(input cyc_t c, input bit taken_now, input logic [1:0] tsel,
                               input logic pz);
        bit halt_now;
        halt_now = 1'b0;
        c.pcen = 1'b1;
        if (m_pend) begin
            c.sel    = m_psel;
            halt_now = m_phalt;
            m_pend   = 1'b0;
        end
        if (taken_now) begin
            m_pend  = 1'b1;
            m_psel  = tsel;
            m_phalt = pz;
        end
        sched.push_back(c);
        if (halt_now) m_halted = 1'b1;
    endtask

    // acc: 0 word (strict alignment), 1 half, 2 byte.
    task automatic instr(input string nm, input logic [31:0] w, input kind_e k, input bit link,
                         input logic [1:0] tsel, input int acc, input int fw, input int mw,
                         input logic [1:0] al, input logic cond, input logic pz,
                         input string pin);
        cyc_t       c;
        logic [3:0] be;
        bit         mis;
        for (int i = 0; i <= fw; i++) begin
            c = blank({nm, "/fetch"});
            c.rdata = w;
            c.wr    = (i < fw);
            c.ird   = 1'b1;
            sched.push_back(c);
        end
        c = blank({nm, "/exec"});
        c.is_true = cond;
        c.pz      = pz;
        c.al      = al;
        case (k)
            KAlu: begin
                c.rwe = 1'b1;
                c.pin = pin;
                push_retire(c, 1'b0, 2'b00, 1'b0);
            end
            KBranch: begin
                c.rwe = link & cond;
                c.pin = pin;
                push_retire(c, cond, tsel, pz);
            end
            KJump: begin
                c.rwe = link;
                c.pin = pin;
                push_retire(c, 1'b1, tsel, pz);
            end
            KMulDiv: begin
                c.ms = 1'b1;
                sched.push_back(c);
                for (int i = 1; i < MD; i++) sched.push_back(blank({nm, "/busy"}));
                c = blank({nm, "/done"});
                c.hw  = 1'b1;
                c.pin = pin;
                push_retire(c, 1'b0, 2'b00, 1'b0);
            end
            default: begin
                sched.push_back(c);
                case (acc)
                    0:       begin be = 4'b1111; mis = (al != 2'b00); end
                    1:       begin be = al[1] ? 4'b1100 : 4'b0011; mis = al[0]; end
                    default: begin be = 4'b0001 << al; mis = 1'b0; end
                endcase
                c    = blank({nm, "/mem"});
                c.al = al;
                if (mis) begin
                    c.pin = pin;
                    push_retire(c, 1'b0, 2'b00, 1'b0);
                end else begin
                    c.drd = (k == KLoad);
                    c.dwr = (k == KStore);
                    c.be  = be;
                    for (int i = 0; i < mw; i++) begin
                        c.wr = 1'b1;
                        sched.push_back(c);
                    end
                    c.wr  = 1'b0;
                    c.rwe = (k == KLoad);
                    c.pin = pin;
                    push_retire(c, 1'b0, 2'b00, 1'b0);
                end
            end
        endcase
    endtask

    task automatic halt_cycles(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c     = blank("halt");
            c.act = 1'b0;
            c.pin = "halt";
            sched.push_back(c);
        end
    endtask

    // Cycle compare against the model, plus literal pins at the hand-computed points.
    always @(negedge clk) begin
        if (cur_valid) begin
            check(cur.tag, {18'd0, bus.active, bus.instr_read, bus.data_read, bus.data_write,
                  bus.byte_enable, bus.reg_write_enable, bus.pc_en, bus.pc_sel,
                  bus.muldiv_start, bus.hilo_write}, {18'd0, pack(cur)});
            if (cur.pin == "addu")
                check("addu rwe/pc_en", {30'd0, bus.reg_write_enable, bus.pc_en}, 32'h3);
            else if (cur.pin == "sb")
                check("sb dwr/be", {27'd0, bus.data_write, bus.byte_enable}, 32'h14);
            else if (cur.pin == "sh")
                check("sh_mis dwr/pc_en", {30'd0, bus.data_write, bus.pc_en}, 32'h1);
            else if (cur.pin == "slot")
                check("slot rwe/pc_sel", {29'd0, bus.reg_write_enable, bus.pc_sel}, 32'h5);
            else if (cur.pin == "hilo")
                check("mult hilo/pc_en", {30'd0, bus.hilo_write, bus.pc_en}, 32'h3);
            else if (cur.pin == "halt")
                check("halt active/ird", {30'd0, bus.active, bus.instr_read}, 32'h0);
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cur_valid = 1'b0;
        m_pend    = 1'b0;
        m_phalt   = 1'b0;
        m_halted  = 1'b0;
        m_psel    = 2'b00;
        reset              = 1'b0;
        bus.clk_enable     = 1'b1;
        bus.instr_readdata = '0;
        bus.waitrequest    = 1'b0;
        bus.is_true        = 1'b0;
        bus.addr_low       = 2'b00;
        bus.pc_is_zero     = 1'b0;

        //    name          word          kind     lnk sel    acc fw mw al     c     pz    pin
        instr("addu",       32'h00221821, KAlu,    0, 2'b00, 0, 3, 0, 2'b00, 1'b0, 1'b0, "addu");
        instr("sb",         32'hA0000000, KStore,  0, 2'b00, 2, 0, 0, 2'b10, 1'b0, 1'b0, "sb");
        instr("sh_mis",     32'hA4000000, KStore,  0, 2'b00, 1, 0, 0, 2'b01, 1'b0, 1'b0, "sh");
        instr("lw_wait",    32'h8C000000, KLoad,   0, 2'b00, 0, 1, 2, 2'b00, 1'b0, 1'b0, "");
        instr("lh_hi",      32'h84000000, KLoad,   0, 2'b00, 1, 0, 0, 2'b10, 1'b0, 1'b0, "");
        instr("lb_b3",      32'h80000000, KLoad,   0, 2'b00, 2, 0, 1, 2'b11, 1'b0, 1'b0, "");
        instr("lw_mis",     32'h8C000000, KLoad,   0, 2'b00, 0, 0, 0, 2'b01, 1'b0, 1'b0, "");
        instr("beq_t",      32'h10000004, KBranch, 0, 2'b01, 0, 0, 0, 2'b00, 1'b1, 1'b0, "");
        instr("addiu_slot", 32'h24010001, KAlu,    0, 2'b00, 0, 0, 0, 2'b00, 1'b0, 1'b0, "slot");
        instr("bne_nt",     32'h14000004, KBranch, 0, 2'b01, 0, 0, 0, 2'b00, 1'b0, 1'b0, "");
        instr("bltzal_nt",  32'h04100004, KBranch, 1, 2'b01, 0, 0, 0, 2'b00, 1'b0, 1'b0, "");
        instr("jal",        32'h0C000010, KJump,   1, 2'b10, 0, 0, 0, 2'b00, 1'b1, 1'b0, "");
        instr("sw_slot",    32'hAC000000, KStore,  0, 2'b00, 0, 0, 1, 2'b00, 1'b0, 1'b0, "");
        instr("mult",       32'h00220018, KMulDiv, 0, 2'b00, 0, 0, 0, 2'b00, 1'b0, 1'b0, "hilo");
        instr("jr0",        32'h00000008, KJump,   0, 2'b11, 0, 0, 0, 2'b00, 1'b1, 1'b1, "");
        instr("nop_slot",   32'h00000000, KAlu,    0, 2'b00, 0, 0, 0, 2'b00, 1'b0, 1'b0, "");
        halt_cycles(4);
        check("model reached halt", {31'd0, m_halted}, 32'h1);

        // Reset state, sampled mid-cycle while reset is held.
        @(posedge clk);
        #1;
        check("reset active", {31'd0, bus.active}, 32'h1);
        check("reset strobes", {21'd0, bus.instr_read, bus.data_read, bus.data_write,
              bus.byte_enable, bus.reg_write_enable, bus.pc_en, bus.pc_sel,
              bus.muldiv_start, bus.hilo_write}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < sched.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            bus.instr_readdata = sched[i].rdata;
            bus.waitrequest    = sched[i].wr;
            bus.is_true        = sched[i].is_true;
            bus.addr_low       = sched[i].al;
            bus.pc_is_zero     = sched[i].pz;
            cur                = sched[i];
            cur_valid          = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid       = 1'b0;
        bus.waitrequest = 1'b0;
        bus.pc_is_zero  = 1'b0;

        // Reset while a load is stalled in MEM.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset              = 1'b1;
        bus.instr_readdata = 32'h8C000000;
        bus.waitrequest    = 1'b0;
        bus.addr_low       = 2'b00;
        @(posedge clk);
        #1;
        bus.waitrequest = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mem stall data_read", {31'd0, bus.data_read}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset drops data_read", {30'd0, bus.data_read, bus.instr_read}, 32'h0);
        check("async reset active", {31'd0, bus.active}, 32'h1);
        @(posedge clk);
        #3;
        reset           = 1'b1;
        bus.waitrequest = 1'b0;
        #1;
        check("post-reset fetch", {29'd0, bus.active, bus.instr_read, bus.data_read}, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
